axi_pkt_fifo: RTL and testbench

AXI_PKT_FIFO -- requirements
Module: axi_pkt_fifo

---
 rtl/axi_pkt_fifo.sv | 84 ++++++++
 tb/tb_axi_pkt_fifo.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pkt_fifo.sv
// axi_pkt_fifo: store-and-forward AXI-Stream packet FIFO; define AXI_PKT_FIFO_DROP_EN to drop overflowing packets instead of backpressuring
module axi_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  async_reset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   pkt_cnt,
  output logic                  overflow
);
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [DATA_WIDTH:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH:0] rd_q;
  logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
  logic rd_vld, full, stall, rd_en, wr_en, rewind, commit, out_last;
  assign full = (wr_ptr - rd_ptr) == DEPTH;
  assign commit = wr_en && s_axis_tlast;
  assign stall = m_axis_tvalid && !m_axis_tready;
  assign rd_en = (rd_ptr != commit_ptr) && !stall;
  assign out_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;
`ifdef AXI_PKT_FIFO_DROP_EN
  typedef enum logic {PASS, DROP} state_t;
  state_t state, state_nx;
  logic drop_done;
  assign s_axis_tready = 1'b1;
  always_comb begin
    wr_en = s_axis_tvalid && state == PASS && !full;
    rewind = s_axis_tvalid && state == PASS && full;
    drop_done = s_axis_tvalid && s_axis_tlast && (state == DROP || rewind);
    state_nx = drop_done ? PASS : rewind ? DROP : state;
  end
  always_ff @(posedge clk or posedge async_reset)
    if (async_reset) begin
      state <= PASS;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      overflow <= drop_done;
    end
`else
  assign s_axis_tready = !full;
  assign wr_en = s_axis_tvalid && !full;
  assign rewind = 1'b0;
  assign overflow = 1'b0;
`endif
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  always_ff @(posedge clk or posedge async_reset)
    if (async_reset) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      pkt_cnt <= '0;
    end else begin
      wr_ptr <= rewind ? commit_ptr : wr_en ? wr_ptr + ONE : wr_ptr;
      if (commit) commit_ptr <= wr_ptr + ONE;
      if (commit != out_last) pkt_cnt <= commit ? pkt_cnt + ONE : pkt_cnt - ONE;
    end
  always_ff @(posedge clk or posedge async_reset)
    if (async_reset) begin
      rd_ptr <= '0;
      rd_vld <= 1'b0;
      rd_q <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else if (!stall) begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + ONE;
      end
      m_axis_tvalid <= rd_vld;
      {m_axis_tlast, m_axis_tdata} <= rd_q;
    end
endmodule

// File: tb/tb_axi_pkt_fifo.sv
// tb_axi_pkt_fifo: randomized self-checking bench for axi_pkt_fifo with a 16-beat buffer
module tb_axi_pkt_fifo;
  logic clk = 1'b0;
  logic async_reset = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tlast = 1'b0;
  logic m_axis_tready = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic s_axis_tready, m_axis_tvalid, m_axis_tlast, overflow;
  logic [31:0] m_axis_tdata;
  logic [4:0] pkt_cnt;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];
  int out_cyc[$];

  axi_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk),
    .async_reset(async_reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // output handshakes and overflow pulses are sampled mid-cycle, ahead of the edge that completes them
  always @(negedge clk) begin
    cyc++;
    if (!async_reset && m_axis_tvalid && m_axis_tready) begin
      out_q.push_back({m_axis_tlast, m_axis_tdata});
      out_cyc.push_back(cyc);
    end
    if (!async_reset && overflow) ovf_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d expected to finish earlier", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic send_pkt(input int len, input logic [11:0] id, input bit rnd, output int stalls);
    stalls = 0;
    for (int b = 0; b < len; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = {id, rnd ? 20'($urandom) : 20'(b + 1)};
      s_axis_tlast = (b == len - 1);
      while (!s_axis_tready) begin
        if (stalls == 2000) begin
          tests++;
          fails++;
          $display("FAIL send_timeout id=%h beat=%0d tready=%b expected 1", id, b, s_axis_tready);
          s_axis_tvalid = 1'b0;
          s_axis_tlast = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        stalls++;
      end
      exp_q.push_back({s_axis_tlast, s_axis_tdata});
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((pkt_cnt != 0 || m_axis_tvalid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 3000) begin
      tests++;
      fails++;
      $display("FAIL %s drain_timeout pkt_cnt=%0d expected 0", name, pkt_cnt);
    end
  endtask

  task automatic test_reset();
    #1 async_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b expected 0", m_axis_tvalid); end
    tests++;
    if ({m_axis_tlast, m_axis_tdata} !== 33'h0) begin fails++; $display("FAIL reset_data got=%h expected 0", {m_axis_tlast, m_axis_tdata}); end
    tests++;
    if (pkt_cnt !== 5'd0) begin fails++; $display("FAIL reset_pkt_cnt got=%0d expected 0", pkt_cnt); end
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b expected 0", overflow); end
    #2 async_reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL reset_tready got=%b expected 1", s_axis_tready); end
  endtask

  task automatic test_single();
    int st;
    int ob = out_q.size();
    m_axis_tready = 1'b1;
    send_pkt(4, 12'h0, 1'b0, st);
    tests++;
    if (m_axis_tvalid !== 1'b0 || pkt_cnt !== 5'd1) begin
      fails++; $display("FAIL single_commit tvalid=%b pkt_cnt=%0d expected 0/1", m_axis_tvalid, pkt_cnt);
    end
    @(posedge clk);
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL single_lat1 tvalid=%b expected 0", m_axis_tvalid); end
    @(posedge clk);
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1) begin
      fails++; $display("FAIL single_lat2 tvalid=%b tdata=%h expected 1/00000001", m_axis_tvalid, m_axis_tdata);
    end
    wait_drain("single");
    tests++;
    if (out_q.size() - ob != 4) begin fails++; $display("FAIL single_count got=%0d expected 4", out_q.size() - ob); end
    for (int b = 0; b < 4 && ob + b < out_q.size(); b++) begin
      tests++;
      if (out_q[ob + b] !== {b == 3, 32'(b + 1)}) begin
        fails++; $display("FAIL single_beat%0d got=%h expected=%h", b, out_q[ob + b], {b == 3, 32'(b + 1)});
      end
    end
    tests++;
    if (pkt_cnt !== 5'd0) begin fails++; $display("FAIL single_pkt_cnt got=%0d expected 0", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    int st, gaps;
    int ob = out_q.size();
    int eb = exp_q.size();
    m_axis_tready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(5, 12'h10 + 12'(p), 1'b1, st);
    repeat (4) begin @(posedge clk); #1; end
    tests++;
    if (pkt_cnt !== 5'd3) begin fails++; $display("FAIL b2b_pkt_cnt got=%0d expected 3", pkt_cnt); end
    m_axis_tready = 1'b1;
    wait_drain("b2b");
    tests++;
    if (out_q.size() - ob != 15) begin fails++; $display("FAIL b2b_count got=%0d expected 15", out_q.size() - ob); end
    gaps = 0;
    for (int b = 0; b < 15 && ob + b < out_q.size(); b++) begin
      tests++;
      if (out_q[ob + b] !== exp_q[eb + b]) begin
        fails++; $display("FAIL b2b_beat%0d got=%h expected=%h", b, out_q[ob + b], exp_q[eb + b]);
      end
      if (b > 0 && out_cyc[ob + b] != out_cyc[ob + b - 1] + 1) gaps++;
    end
    tests++;
    if (gaps != 0) begin fails++; $display("FAIL b2b_gaps got=%0d expected 0", gaps); end
  endtask

`ifdef AXI_PKT_FIFO_DROP_EN
  task automatic test_drop();
    int st, eb;
    int ob = out_q.size();
    int vb = ovf_cnt;
    m_axis_tready = 1'b0;
    send_pkt(20, 12'h200, 1'b1, st);
    tests++;
    if (overflow !== 1'b1 || pkt_cnt !== 5'd0) begin
      fails++; $display("FAIL drop_pulse overflow=%b pkt_cnt=%0d expected 1/0", overflow, pkt_cnt);
    end
    @(posedge clk);
    #1;
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL drop_pulse_width overflow=%b expected 0", overflow); end
    eb = exp_q.size();
    send_pkt(3, 12'h201, 1'b1, st);
    tests++;
    if (pkt_cnt !== 5'd1) begin fails++; $display("FAIL drop_pkt_cnt got=%0d expected 1", pkt_cnt); end
    m_axis_tready = 1'b1;
    wait_drain("drop");
    tests++;
    if (out_q.size() - ob != 3) begin fails++; $display("FAIL drop_count got=%0d expected 3", out_q.size() - ob); end
    for (int b = 0; b < 3 && ob + b < out_q.size(); b++) begin
      tests++;
      if (out_q[ob + b] !== exp_q[eb + b]) begin
        fails++; $display("FAIL drop_beat%0d got=%h expected=%h", b, out_q[ob + b], exp_q[eb + b]);
      end
    end
    tests++;
    if (ovf_cnt - vb != 1) begin fails++; $display("FAIL drop_pulses got=%0d expected 1", ovf_cnt - vb); end
  endtask
`else
  task automatic test_full();
    int st;
    int ob = out_q.size();
    int eb = exp_q.size();
    m_axis_tready = 1'b0;
    send_pkt(16, 12'h100, 1'b1, st);
    tests++;
    if (st != 0) begin fails++; $display("FAIL full_accept stalls=%0d expected 0", st); end
    tests++;
    if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL full_flag tready=%b expected 0", s_axis_tready); end
    send_pkt(1, 12'h101, 1'b1, st);
    tests++;
    if (st == 0) begin fails++; $display("FAIL full_stall stalls=%0d expected nonzero", st); end
    tests++;
    if (pkt_cnt !== 5'd2) begin fails++; $display("FAIL full_pkt_cnt got=%0d expected 2", pkt_cnt); end
    m_axis_tready = 1'b1;
    wait_drain("full");
    tests++;
    if (out_q.size() - ob != 17) begin fails++; $display("FAIL full_count got=%0d expected 17", out_q.size() - ob); end
    for (int b = 0; b < 17 && ob + b < out_q.size(); b++) begin
      tests++;
      if (out_q[ob + b] !== exp_q[eb + b]) begin
        fails++; $display("FAIL full_beat%0d got=%h expected=%h", b, out_q[ob + b], exp_q[eb + b]);
      end
    end
  endtask
`endif

  task automatic test_simultaneous();
    int st;
    int ob = out_q.size();
    int eb = exp_q.size();
    m_axis_tready = 1'b1;
    send_pkt(2, 12'h400, 1'b1, st);
    send_pkt(4, 12'h401, 1'b1, st);
    tests++;
    if (out_q.size() - ob != 2 || out_q[out_q.size() - 1][32] !== 1'b1) begin
      fails++; $display("FAIL simul_align beats=%0d expected 2 ending in tlast", out_q.size() - ob);
    end
    tests++;
    if (pkt_cnt !== 5'd1) begin fails++; $display("FAIL simul_pkt_cnt got=%0d expected 1", pkt_cnt); end
    wait_drain("simul");
    tests++;
    if (out_q.size() - ob != 6) begin fails++; $display("FAIL simul_count got=%0d expected 6", out_q.size() - ob); end
    for (int b = 0; b < 6 && ob + b < out_q.size(); b++) begin
      tests++;
      if (out_q[ob + b] !== exp_q[eb + b]) begin
        fails++; $display("FAIL simul_beat%0d got=%h expected=%h", b, out_q[ob + b], exp_q[eb + b]);
      end
    end
  endtask

  task automatic test_random();
    int lens[$];
    int st, oi, ei;
    int dropped = 0;
    int ob = out_q.size();
    int eb = exp_q.size();
    int vb = ovf_cnt;
    bit done = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          lens.push_back(int'($urandom_range(1, 16)));
          send_pkt(lens[p], 12'(p), 1'b1, st);
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        wait_drain("random");
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1'b1;
    oi = ob;
    ei = eb;
    foreach (lens[p]) begin
      int bad = -1;
`ifdef AXI_PKT_FIFO_DROP_EN
      if (oi >= out_q.size() || out_q[oi][31:20] != exp_q[ei][31:20]) begin
        dropped++;
        ei += lens[p];
        continue;
      end
`endif
      for (int b = 0; b < lens[p]; b++)
        if (bad < 0 && (oi + b >= out_q.size() || out_q[oi + b] !== exp_q[ei + b])) bad = b;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL random_pkt%0d beat%0d got=%h expected=%h", p, bad,
                 (oi + bad < out_q.size()) ? out_q[oi + bad] : 33'h0, exp_q[ei + bad]);
      end
      oi += lens[p];
      ei += lens[p];
    end
    tests++;
    if (oi != out_q.size()) begin fails++; $display("FAIL random_extra got=%0d beats expected %0d", out_q.size() - ob, oi - ob); end
    tests++;
    if (dropped != ovf_cnt - vb) begin fails++; $display("FAIL random_overflow pulses=%0d expected %0d", ovf_cnt - vb, dropped); end
    tests++;
    if (pkt_cnt !== 5'd0) begin fails++; $display("FAIL random_pkt_cnt got=%0d expected 0", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int st, ob, eb;
    m_axis_tready = 1'b0;
    send_pkt(2, 12'h300, 1'b1, st);
    repeat (3) begin @(posedge clk); #1; end
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_axis_tdata = {12'h301, 20'(b + 1)};
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    tests++;
    if (m_axis_tvalid !== 1'b1 || pkt_cnt !== 5'd1) begin
      fails++; $display("FAIL rstmid_pre tvalid=%b pkt_cnt=%0d expected 1/1", m_axis_tvalid, pkt_cnt);
    end
    #2 async_reset = 1'b1;
    #1;
    tests++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, pkt_cnt, overflow} !== '0) begin
      fails++; $display("FAIL rstmid_zero tvalid=%b tlast=%b tdata=%h pkt_cnt=%0d overflow=%b expected all 0",
                        m_axis_tvalid, m_axis_tlast, m_axis_tdata, pkt_cnt, overflow);
    end
    @(posedge clk);
    #3 async_reset = 1'b0;
    ob = out_q.size();
    m_axis_tready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if (out_q.size() != ob) begin fails++; $display("FAIL rstmid_stale got=%0d beats expected 0", out_q.size() - ob); end
    tests++;
    if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL rstmid_tready got=%b expected 1", s_axis_tready); end
    eb = exp_q.size();
    send_pkt(3, 12'h302, 1'b1, st);
    wait_drain("rstmid");
    tests++;
    if (out_q.size() - ob != 3) begin fails++; $display("FAIL rstmid_count got=%0d expected 3", out_q.size() - ob); end
    for (int b = 0; b < 3 && ob + b < out_q.size(); b++) begin
      tests++;
      if (out_q[ob + b] !== exp_q[eb + b]) begin
        fails++; $display("FAIL rstmid_beat%0d got=%h expected=%h", b, out_q[ob + b], exp_q[eb + b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef AXI_PKT_FIFO_DROP_EN
    test_drop();
`else
    test_full();
`endif
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
